// File: rtl/mprj_io_cfg_pkg.sv
// rtl/mprj_io_cfg_pkg.sv - shared state encoding and config word layout for the GPIO config loader
//
// Purpose: FSM state type, default per-pad config width and the bit positions of
//          each field inside one pad config word.
// Ports:   none (package).
package mprj_io_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_LOAD  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam int CFG_BITS_DEF = 13;

  localparam int FLD_MGMT_EN     = 0;
  localparam int FLD_OEB         = 1;
  localparam int FLD_HLDH_N      = 2;
  localparam int FLD_INP_DIS     = 3;
  localparam int FLD_IB_MODE_SEL = 4;
  localparam int FLD_ANALOG_EN   = 5;
  localparam int FLD_ANALOG_SEL  = 6;
  localparam int FLD_ANALOG_POL  = 7;
  localparam int FLD_SLOW        = 8;
  localparam int FLD_VTRIP_SEL   = 9;
  localparam int FLD_DM_LSB      = 10;
  localparam int FLD_DM_MSB      = 12;

  // Drive-mode field of a pad config word.
  function automatic logic [2:0] cfg_dm(input logic [CFG_BITS_DEF-1:0] word);
    return word[FLD_DM_MSB:FLD_DM_LSB];
  endfunction

endpackage

// File: rtl/mprj_io_cfg_clkgen.sv
// rtl/mprj_io_cfg_clkgen.sv - serial_clock phase generator for the GPIO config chain
//
// Purpose: while run is high, produces a serial clock that is low for CLK_DIV cycles
//          then high for CLK_DIV cycles, starting with the low phase. bit_end marks the
//          last cycle of a high phase, i.e. the edge at which the next bit begins.
// Ports:   clk      in   sole clock
//          rst      in   synchronous reset, active high
//          run      in   enable; low holds the clock low and the phase counter at 0
//          sclk     out  registered serial clock
//          bit_end  out  strobe on the final cycle of each bit period
module mprj_io_cfg_clkgen
  import mprj_io_cfg_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic sclk,
  output logic bit_end
);

  logic [3:0] phase;
  logic       phase_last;

  assign phase_last = (phase == 4'(CLK_DIV - 1));
  assign bit_end    = run & sclk & phase_last;

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      phase <= 4'd0;
      sclk  <= 1'b0;
    end else if (phase_last) begin
      phase <= 4'd0;
      sclk  <= ~sclk;
    end else begin
      phase <= phase + 4'd1;
    end
  end

endmodule

// File: rtl/mprj_io_cfg_loader.sv
// rtl/mprj_io_cfg_loader.sv - loads per-pad config words from RAM into the GPIO serial chain
//
// Purpose: fetches one CFG_BITS word per pad (farthest pad first), shifts the whole
//          image MSB first into the chain of GPIO control blocks, then pulses
//          serial_load so all pads apply their new configuration together.
//          Build option MPRJ_IO_CFG_AUTOLOAD_EN: the first cycle after reset release
//          acts as an accepted xfer_start (once per reset release).
// Ports:   wb_clk_i      in   sole clock
//          wb_rst_i      in   synchronous reset, active high
//          xfer_start    in   reload request, honoured only when idle
//          busy          out  transfer in progress (through the done cycle)
//          done          out  one-cycle completion pulse
//          cfg_rd_en     out  config RAM read strobe
//          cfg_rd_addr   out  pad index being fetched
//          cfg_rd_data   in   config word, valid the cycle after cfg_rd_en
//          serial_clock  out  chain shift clock
//          serial_data   out  chain data
//          serial_load   out  chain latch strobe
module mprj_io_cfg_loader
  import mprj_io_cfg_pkg::*;
#(
  parameter int NUM_PADS = 38,
  parameter int CFG_BITS = CFG_BITS_DEF,
  parameter int CLK_DIV  = 4,
  parameter int AW       = 6
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                xfer_start,
  output logic                busy,
  output logic                done,
  output logic                cfg_rd_en,
  output logic [AW-1:0]       cfg_rd_addr,
  input  logic [CFG_BITS-1:0] cfg_rd_data,
  output logic                serial_clock,
  output logic                serial_data,
  output logic                serial_load
);

  localparam int BW = $clog2(CFG_BITS);

  state_t                state;
  logic [AW-1:0]         pad;
  logic [BW-1:0]         bit_cnt;
  // Holds the bits still to be sent; the MSB goes straight to serial_data.
  logic [CFG_BITS-2:0]   shreg;
  logic [3:0]            ld_cnt;
  logic                  start_req;
  logic                  run;
  logic                  bit_end;

`ifdef MPRJ_IO_CFG_AUTOLOAD_EN
  // High only on the first cycle after reset is released.
  logic autoload_pend;
  always_ff @(posedge wb_clk_i) begin
    autoload_pend <= wb_rst_i;
  end
  assign start_req = xfer_start | autoload_pend;
`else
  assign start_req = xfer_start;
`endif

  assign run = (state == ST_SHIFT);

  mprj_io_cfg_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .run     (run),
    .sclk    (serial_clock),
    .bit_end (bit_end)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_rd_en   <= 1'b0;
      cfg_rd_addr <= '0;
      serial_data <= 1'b0;
      serial_load <= 1'b0;
      pad         <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      ld_cnt      <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_req) begin
            state       <= ST_FETCH;
            busy        <= 1'b1;
            pad         <= AW'(NUM_PADS - 1);
            cfg_rd_en   <= 1'b1;
            cfg_rd_addr <= AW'(NUM_PADS - 1);
          end
        end
        ST_FETCH: begin
          cfg_rd_en <= 1'b0;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          // First bit is presented as the low phase of the first bit period starts.
          serial_data <= cfg_rd_data[CFG_BITS-1];
          shreg       <= cfg_rd_data[CFG_BITS-2:0];
          bit_cnt     <= '0;
          state       <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (bit_end) begin
            if (bit_cnt == BW'(CFG_BITS - 1)) begin
              if (pad == '0) begin
                state       <= ST_LOAD;
                serial_load <= 1'b1;
                ld_cnt      <= 4'd0;
              end else begin
                pad         <= pad - AW'(1);
                cfg_rd_addr <= pad - AW'(1);
                cfg_rd_en   <= 1'b1;
                state       <= ST_FETCH;
              end
            end else begin
              bit_cnt     <= bit_cnt + BW'(1);
              serial_data <= shreg[CFG_BITS-2];
              shreg       <= {shreg[CFG_BITS-3:0], 1'b0};
            end
          end
        end
        ST_LOAD: begin
          if (ld_cnt == 4'(CLK_DIV - 1)) begin
            serial_load <= 1'b0;
            done        <= 1'b1;
            state       <= ST_DONE;
          end else begin
            ld_cnt <= ld_cnt + 4'd1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mprj_io_cfg_loader.sv
// tb/tb_mprj_io_cfg_loader.sv - self-checking bench for mprj_io_cfg_loader
module tb_mprj_io_cfg_loader;

  localparam int ND   = 3;
  localparam int NP_A = 2;
  localparam int DV_A = 1;
  localparam int NP_B = 38;
  localparam int DV_B = 4;
  localparam int NP_C = 3;
  localparam int DV_C = 3;
  localparam int NP [ND] = '{NP_A, NP_B, NP_C};
  localparam int DV [ND] = '{DV_A, DV_B, DV_C};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int ncyc = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  logic        rst     [ND] = '{default: 1'b1};
  logic        xs      [ND] = '{default: 1'b0};
  logic        busy    [ND];
  logic        done    [ND];
  logic        rd_en   [ND];
  logic [5:0]  rd_addr [ND];
  logic [12:0] rd_data [ND];
  logic        sclk    [ND];
  logic        sdata   [ND];
  logic        sload   [ND];

  logic [12:0] ram [ND][64];

  always @(posedge clk)
    for (int d = 0; d < ND; d++)
      if (rd_en[d]) rd_data[d] <= ram[d][rd_addr[d]];

  mprj_io_cfg_loader #(.NUM_PADS(NP_A), .CFG_BITS(13), .CLK_DIV(DV_A), .AW(6)) u_a (
    .wb_clk_i(clk), .wb_rst_i(rst[0]), .xfer_start(xs[0]), .busy(busy[0]), .done(done[0]),
    .cfg_rd_en(rd_en[0]), .cfg_rd_addr(rd_addr[0]), .cfg_rd_data(rd_data[0]),
    .serial_clock(sclk[0]), .serial_data(sdata[0]), .serial_load(sload[0]));

  mprj_io_cfg_loader #(.NUM_PADS(NP_B), .CFG_BITS(13), .CLK_DIV(DV_B), .AW(6)) u_b (
    .wb_clk_i(clk), .wb_rst_i(rst[1]), .xfer_start(xs[1]), .busy(busy[1]), .done(done[1]),
    .cfg_rd_en(rd_en[1]), .cfg_rd_addr(rd_addr[1]), .cfg_rd_data(rd_data[1]),
    .serial_clock(sclk[1]), .serial_data(sdata[1]), .serial_load(sload[1]));

  mprj_io_cfg_loader #(.NUM_PADS(NP_C), .CFG_BITS(13), .CLK_DIV(DV_C), .AW(6)) u_c (
    .wb_clk_i(clk), .wb_rst_i(rst[2]), .xfer_start(xs[2]), .busy(busy[2]), .done(done[2]),
    .cfg_rd_en(rd_en[2]), .cfg_rd_addr(rd_addr[2]), .cfg_rd_data(rd_data[2]),
    .serial_clock(sclk[2]), .serial_data(sdata[2]), .serial_load(sload[2]));

  // Reference model: one 13-bit shift register per pad, pad 0 nearest the loader,
  // plus the latched pad configuration captured on each serial_load rise.
  logic [12:0] chain [ND][64];
  logic [12:0] pads  [ND][64];
  int rises     [ND] = '{default: 0};
  int dones     [ND] = '{default: 0};
  int loads     [ND] = '{default: 0};
  int done_cyc  [ND] = '{default: 0};
  int xrise     [ND] = '{default: 0};
  int run_len   [ND] = '{default: 0};
  int phase_err [ND] = '{default: 0};
  int hold_err  [ND] = '{default: 0};
  logic psclk  [ND] = '{default: 1'b0};
  logic psdata [ND] = '{default: 1'b0};
  logic psload [ND] = '{default: 1'b0};
  bit bitq [$];

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (rst[d]) begin
        psclk[d] = 1'b0; psdata[d] = 1'b0; psload[d] = 1'b0;
        run_len[d] = 0; xrise[d] = 0;
      end else begin
        if (sclk[d] !== psclk[d]) begin
          if (sclk[d]) begin
            // Low phase is CLK_DIV cycles; a new pad adds the fetch and wait cycles.
            if (xrise[d] > 0)
              if (run_len[d] != ((xrise[d] % 13 == 0) ? DV[d] + 2 : DV[d])) phase_err[d]++;
            xrise[d]++;
            rises[d]++;
            for (int p = NP[d] - 1; p > 0; p--)
              chain[d][p] = {chain[d][p][11:0], chain[d][p-1][12]};
            chain[d][0] = {chain[d][0][11:0], sdata[d]};
            if (d == 0) bitq.push_back(sdata[d]);
          end else if (run_len[d] != DV[d]) begin
            phase_err[d]++;
          end
          run_len[d] = 1;
        end else begin
          run_len[d]++;
          if (sclk[d] && (sdata[d] !== psdata[d])) hold_err[d]++;
        end
        if (sload[d] && !psload[d]) begin
          for (int p = 0; p < NP[d]; p++) pads[d][p] = chain[d][p];
          loads[d]++;
        end
        if (done[d]) begin
          dones[d]++;
          done_cyc[d] = ncyc;
        end
        if (!busy[d]) xrise[d] = 0;
        psclk[d] = sclk[d]; psdata[d] = sdata[d]; psload[d] = sload[d];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_cyc(input int np, input int dv);
    return np * (2 + 2 * 13 * dv) + dv + 1;
  endfunction

  function automatic int pad_miss(input int d);
    int n = 0;
    for (int p = 0; p < NP[d]; p++) if (pads[d][p] !== ram[d][p]) n++;
    return n;
  endfunction

  // Start a transfer with a one-cycle xfer_start pulse and wait for done.
  task automatic run_xfer(input int d, input int limit, output int elapsed);
    int k;
    int db;
    bit ok;
    @(negedge clk); #1;
    k = ncyc; db = dones[d]; xs[d] = 1'b1;
    @(negedge clk); #1;
    xs[d] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (dones[d] != db) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    chk($sformatf("done_timeout_%0d", d), 64'(ok), 64'd1);
    elapsed = done_cyc[d] - k;
  endtask

  task automatic wait_all_done(input int base0, input int base1, input int base2, input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk); #1;
      if (dones[0] > base0 && dones[1] > base1 && dones[2] > base2) begin ok = 1'b1; break; end
    end
    chk("autoload_done_timeout", 64'(ok), 64'd1);
  endtask

  int el, rb, qb, db, k, ok_i;
  logic [25:0] seq;
  logic [12:0] keep [64];

  initial begin
    for (int d = 0; d < ND; d++)
      for (int p = 0; p < 64; p++) ram[d][p] = 13'($urandom);
    ram[0][1] = 13'h1ABC;
    ram[0][0] = 13'h0555;

    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++)
      chk($sformatf("reset_values_%0d", d),
          64'({busy[d], done[d], rd_en[d], rd_addr[d], sclk[d], sdata[d], sload[d]}), 64'd0);

    #1;
    for (int d = 0; d < ND; d++) rst[d] = 1'b0;
`ifdef MPRJ_IO_CFG_AUTOLOAD_EN
    @(negedge clk); #1;
    for (int d = 0; d < ND; d++) chk($sformatf("autoload_busy_%0d", d), 64'(busy[d]), 64'd1);
    wait_all_done(0, 0, 0, 6000);
    repeat (10) @(negedge clk); #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("autoload_one_done_%0d", d), 64'(dones[d]), 64'd1);
      chk($sformatf("autoload_pads_%0d", d), 64'(pad_miss(d)), 64'd0);
    end
`else
    repeat (20) @(negedge clk); #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("idle_after_reset_%0d", d), 64'(busy[d]), 64'd0);
      chk($sformatf("no_edges_after_reset_%0d", d), 64'(rises[d]), 64'd0);
    end
`endif

    // Two pads, CLK_DIV=1, fixed image.
    qb = bitq.size(); rb = rises[0];
    run_xfer(0, 500, el);
    chk("a_done_cycle", 64'(el), 64'(exp_cyc(NP_A, DV_A)));
    chk("a_done_cycle_58", 64'(el), 64'd58);
    chk("a_rises", 64'(rises[0] - rb), 64'd26);
    seq = '0;
    for (int i = 0; i < 26; i++)
      if (qb + i < bitq.size()) seq = {seq[24:0], 1'(bitq[qb + i])};
    chk("a_bit_sequence", 64'(seq), 64'({13'h1ABC, 13'h0555}));
    chk("a_pads", 64'(pad_miss(0)), 64'd0);

    // Boundary words: all ones and all zeros.
    ram[0][1] = 13'h1FFF;
    ram[0][0] = 13'h0000;
    run_xfer(0, 500, el);
    chk("a_pads_extreme", 64'(pad_miss(0)), 64'd0);

    // Default parameters, random image, xfer_start held high throughout.
    for (int p = 0; p < NP_B; p++) ram[1][p] = 13'($urandom);
    rb = rises[1]; db = dones[1];
    @(negedge clk); #1;
    k = ncyc; xs[1] = 1'b1;
    ok_i = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk); #1;
      if (dones[1] != db) begin ok_i = 1; break; end
    end
    chk("b_done_timeout", 64'(ok_i), 64'd1);
    chk("b_done_cycle", 64'(done_cyc[1] - k), 64'(exp_cyc(NP_B, DV_B)));
    @(negedge clk); #1;
    chk("b_start_in_done_ignored", 64'(busy[1]), 64'd0);
    xs[1] = 1'b0;
    repeat (20) @(negedge clk); #1;
    chk("b_single_done", 64'(dones[1] - db), 64'd1);
    chk("b_idle_after", 64'(busy[1]), 64'd0);
    chk("b_rises", 64'(rises[1] - rb), 64'(NP_B * 13));
    chk("b_pads", 64'(pad_miss(1)), 64'd0);

    // Reset during pad 20, bit 5: latched pad config must stay as before.
    for (int p = 0; p < 64; p++) keep[p] = ram[1][p];
    for (int p = 0; p < NP_B; p++) ram[1][p] = 13'($urandom);
    rb = rises[1]; db = loads[1];
    @(negedge clk); #1;
    xs[1] = 1'b1;
    @(negedge clk); #1;
    xs[1] = 1'b0;
    ok_i = 0;
    for (int i = 0; i < 5000; i++) begin
      if (rises[1] - rb >= 17 * 13 + 5) begin ok_i = 1; break; end
      @(negedge clk); #1;
    end
    chk("b_reach_pad20_timeout", 64'(ok_i), 64'd1);
    chk("b_busy_mid_shift", 64'(busy[1]), 64'd1);
    rst[1] = 1'b1;
    @(negedge clk); #1;
    chk("b_reset_mid_outputs",
        64'({busy[1], done[1], rd_en[1], rd_addr[1], sclk[1], sdata[1], sload[1]}), 64'd0);
    repeat (3) @(negedge clk); #1;
    chk("b_no_load_on_abort", 64'(loads[1] - db), 64'd0);
    ok_i = 0;
    for (int p = 0; p < NP_B; p++) if (pads[1][p] !== keep[p]) ok_i++;
    chk("b_pads_kept", 64'(ok_i), 64'd0);
    rst[1] = 1'b0;
    db = dones[1];
`ifdef MPRJ_IO_CFG_AUTOLOAD_EN
    @(negedge clk); #1;
    chk("b_autoload_after_abort", 64'(busy[1]), 64'd1);
    wait_all_done(dones[0] - 1, db, dones[2] - 1, 6000);
    chk("b_autoload_pads", 64'(pad_miss(1)), 64'd0);
`else
    repeat (10) @(negedge clk); #1;
    chk("b_idle_after_abort", 64'(busy[1]), 64'd0);
    chk("b_no_done_after_abort", 64'(dones[1] - db), 64'd0);
`endif

    // CLK_DIV=3: phase lengths and data stability checked by the monitor.
    rb = rises[2];
    run_xfer(2, 2000, el);
    chk("c_done_cycle", 64'(el), 64'(exp_cyc(NP_C, DV_C)));
    chk("c_rises", 64'(rises[2] - rb), 64'(NP_C * 13));
    chk("c_pads", 64'(pad_miss(2)), 64'd0);

    for (int d = 0; d < ND; d++) begin
      chk($sformatf("phase_lengths_%0d", d), 64'(phase_err[d]), 64'd0);
      chk($sformatf("data_stable_high_%0d", d), 64'(hold_err[d]), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
